branch_seq_ctrl: RTL and testbench
==================================

// Module: branch_seq_ctrl
// PURPOSE
// - Parametrised control sequencer for the conditional-branch steps T3..T6 (brzr/brnz/brpl/brmi).
// - Contains the CON flip-flop. Drives the datapath strobes Gra, Rout, CONin, PCout, Yin, Cout, ADD, Zin, Zlowout and PCin.
// - Placed beside the datapath. The top-level control unit hands over after T2 (IR loaded) and regains control on done.
// PARAMETERS
// - DATA_W      32  width of the bus value tested by the condition logic
// - STEP_CYCLES 1   clock cycles each step T3..T6 is held (>=1), to allow slow bus settling
// PORTS
// - Clock      in   1       system clock, rising edge
// - Clear      in   1       asynchronous, active-high reset
// - start      in   1       begin branch sequence; sampled only in IDLE
// - cond       in   2       IR[20:19] condition: 00 zero, 01 nonzero, 10 positive(msb=0), 11 negative(msb=1)
// - bus_in     in   DATA_W  bus value (Ra via Gra/Rout) during T3
// - Gra,Rout,CONin out 1    T3 strobes
// - PCout,Yin  out  1       T4 strobes
// - Cout,ADD,Zin out 1      T5 strobes
// - Zlowout    out  1       T6 strobe
// - PCin       out  1       T6 strobe, gated: Zlowout & con_ff
// - con_ff     out  1       registered branch condition (BranchMet)
// - busy       out  1       high in any state other than IDLE
// - done       out  1       one-cycle pulse after the last T6 cycle
// BEHAVIOUR
// - Reset: state=IDLE, step counter=0, con_ff=0; every strobe, busy and done = 0.
// - States: IDLE -> T3 -> T4 -> T5 -> T6 -> FIN -> IDLE. Each of T3..T6 lasts exactly STEP_CYCLES cycles (down-counter reloads on entry). FIN lasts 1 cycle.
// - Strobes are Moore outputs, decoded from state only. They are registered and change only on a clock edge.
// - Timing: start=1 in IDLE at edge k gives T3 active from edge k through k+STEP_CYCLES.
// - busy=1 for 4*STEP_CYCLES+1 cycles. done=1 only in FIN.
// - CON: on the last T3 cycle edge, con_ff <= f(cond, bus_in).
//   - zero:     bus_in==0
//   - nonzero:  bus_in!=0
//   - positive: bus_in[DATA_W-1]==0
//   - negative: bus_in[DATA_W-1]==1
// - con_ff holds its value until the next T3. It is not cleared in IDLE.
// - PCin asserts only in T6 and only when con_ff=1. Zlowout asserts in T6 regardless of con_ff.
// - start while busy: ignored, with no queueing. start held high at FIN->IDLE is accepted on the following IDLE cycle.
// - cond and bus_in are used only in T3. Changes in other states have no effect.
// - Clear mid-sequence returns immediately (asynchronously) to reset values. No partial strobe survives.
// CONFIGURATION
// - Macro BRANCH_SKIP_EN:
//   - Defined: if con_ff evaluates to 0 at the end of T3, the FSM goes T3 -> FIN directly. T4..T6 strobes never assert and busy lasts STEP_CYCLES+1 cycles.
//   - Undefined: the full T3..T6 sequence always runs. A not-taken branch still performs PC+C into Z but never asserts PCin.
// STRUCTURE
// - Shared package cpu_ctrl_pkg:
//   - state enum (IDLE,T3,T4,T5,T6,FIN)
//   - cond-code constants COND_ZR=2'b00, COND_NZ=2'b01, COND_PL=2'b10, COND_MI=2'b11
// - Sub-module con_ff_logic(Clock, Clear, cond, bus_in, load, con_ff):
//   - combinational condition decode plus the CON register
//   - reusable by other conditional ops
// - Top level: FSM, step counter and output decode.
// TESTING
// - brnz, cond=01, bus_in=10, STEP_CYCLES=1: con_ff=1; PCin=1 for exactly 1 cycle in T6; done at cycle 5 after start.
// - brzr, cond=00, bus_in=0 -> con_ff=1. Then cond=00, bus_in=35 -> con_ff=0, PCin never asserts, Zlowout still pulses (skip off).
// - brpl, bus_in=32'h8000_0000 -> con_ff=0. brmi with the same value -> con_ff=1. brmi, bus_in=32'h7FFF_FFFF -> con_ff=0.
// - STEP_CYCLES=3: each strobe group is high for exactly 3 cycles. busy=13 cycles. start pulsed during T4 is ignored.
// - Clear asserted during T5: Cout/ADD/Zin drop immediately. After release the FSM is IDLE, busy=0, con_ff=0.
// - BRANCH_SKIP_EN defined, cond=01, bus_in=0: T3 lasts STEP_CYCLES, then FIN. PCout/Yin/Zin/Zlowout/PCin never assert.

Source files
------------

// File: rtl/cpu_ctrl_pkg.sv
// Shared types for the CPU control sequencers: step states, branch condition codes
// and the strobe bundle decoded from each step state.
package cpu_ctrl_pkg;

   typedef enum logic [2:0] {
      IDLE = 3'd0,
      T3   = 3'd1,
      T4   = 3'd2,
      T5   = 3'd3,
      T6   = 3'd4,
      FIN  = 3'd5
   } state_t;

   localparam logic [1:0] COND_ZR = 2'b00;
   localparam logic [1:0] COND_NZ = 2'b01;
   localparam logic [1:0] COND_PL = 2'b10;
   localparam logic [1:0] COND_MI = 2'b11;

   typedef struct packed {
      logic gra;
      logic rout;
      logic con_in;
      logic pc_out;
      logic y_in;
      logic c_out;
      logic add;
      logic z_in;
      logic zlow_out;
      logic busy;
      logic done;
   } strobe_t;

   // PCin is deliberately absent: it also depends on the CON flop.
   function automatic strobe_t decode_state(input state_t s);
      strobe_t d;
      d = '0;
      d.busy = (s != IDLE);
      case (s)
         T3: begin
            d.gra    = 1'b1;
            d.rout   = 1'b1;
            d.con_in = 1'b1;
         end
         T4: begin
            d.pc_out = 1'b1;
            d.y_in   = 1'b1;
         end
         T5: begin
            d.c_out = 1'b1;
            d.add   = 1'b1;
            d.z_in  = 1'b1;
         end
         T6:      d.zlow_out = 1'b1;
         FIN:     d.done     = 1'b1;
         default: ;
      endcase
      return d;
   endfunction

endpackage

// File: rtl/con_ff_logic.sv
// Branch condition decode (zero/nonzero/positive/negative) and the CON flip-flop.
// cond_met is the live decode so a caller can act on it in the same cycle it is loaded.
module con_ff_logic
   import cpu_ctrl_pkg::*;
#(
   parameter int DATA_W = 32
) (
   input  logic              Clock,
   input  logic              Clear,
   input  logic [1:0]        cond,
   input  logic [DATA_W-1:0] bus_in,
   input  logic              load,
   output logic              cond_met,
   output logic              con_ff
);

   always_comb begin
      cond_met = 1'b0;
      case (cond)
         COND_ZR: cond_met = (bus_in == '0);
         COND_NZ: cond_met = (bus_in != '0);
         COND_PL: cond_met = ~bus_in[DATA_W-1];
         COND_MI: cond_met =  bus_in[DATA_W-1];
         default: cond_met = 1'b0;
      endcase
   end

   // Holds across IDLE; only a new T3 load or Clear changes it.
   always_ff @(posedge Clock or posedge Clear) begin
      if (Clear) begin
         con_ff <= 1'b0;
      end else if (load) begin
         con_ff <= cond_met;
      end
   end

endmodule

// File: rtl/branch_seq_ctrl.sv
// Conditional-branch sequencer for steps T3..T6, each held STEP_CYCLES cycles, then FIN (done).
// Macro BRANCH_SKIP_EN: a not-taken branch jumps T3 -> FIN, skipping the PC+C steps.
module branch_seq_ctrl
   import cpu_ctrl_pkg::*;
#(
   parameter int DATA_W      = 32,
   parameter int STEP_CYCLES = 1
) (
   input  logic              Clock,
   input  logic              Clear,
   input  logic              start,
   input  logic [1:0]        cond,
   input  logic [DATA_W-1:0] bus_in,
   output logic              Gra,
   output logic              Rout,
   output logic              CONin,
   output logic              PCout,
   output logic              Yin,
   output logic              Cout,
   output logic              ADD,
   output logic              Zin,
   output logic              Zlowout,
   output logic              PCin,
   output logic              con_ff,
   output logic              busy,
   output logic              done
);

   localparam int                CNT_W      = (STEP_CYCLES > 1) ? $clog2(STEP_CYCLES) : 1;
   localparam logic [CNT_W-1:0] CNT_RELOAD = CNT_W'(STEP_CYCLES - 1);
   localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);

   state_t           state;
   state_t           state_nxt;
   logic [CNT_W-1:0] cnt;
   logic [CNT_W-1:0] cnt_nxt;
   logic             step_last;
   logic             load_con;
   logic             cond_met;
   strobe_t          stb;

   assign step_last = (cnt == '0);
   assign load_con  = (state == T3) && step_last;

   con_ff_logic #(
      .DATA_W (DATA_W)
   ) u_con (
      .Clock    (Clock),
      .Clear    (Clear),
      .cond     (cond),
      .bus_in   (bus_in),
      .load     (load_con),
      .cond_met (cond_met),
      .con_ff   (con_ff)
   );

   always_comb begin
      state_nxt = state;
      cnt_nxt   = cnt;
      case (state)
         IDLE: begin
            if (start) begin
               state_nxt = T3;
               cnt_nxt   = CNT_RELOAD;
            end
         end
         T3: begin
            if (step_last) begin
`ifdef BRANCH_SKIP_EN
               if (cond_met) begin
                  state_nxt = T4;
                  cnt_nxt   = CNT_RELOAD;
               end else begin
                  state_nxt = FIN;
               end
`else
               state_nxt = T4;
               cnt_nxt   = CNT_RELOAD;
`endif
            end else begin
               cnt_nxt = cnt - CNT_ONE;
            end
         end
         T4: begin
            if (step_last) begin
               state_nxt = T5;
               cnt_nxt   = CNT_RELOAD;
            end else begin
               cnt_nxt = cnt - CNT_ONE;
            end
         end
         T5: begin
            if (step_last) begin
               state_nxt = T6;
               cnt_nxt   = CNT_RELOAD;
            end else begin
               cnt_nxt = cnt - CNT_ONE;
            end
         end
         T6: begin
            if (step_last) begin
               state_nxt = FIN;
            end else begin
               cnt_nxt = cnt - CNT_ONE;
            end
         end
         FIN:     state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   // Strobes are decoded from the next state into flops so they never glitch.
   always_ff @(posedge Clock or posedge Clear) begin
      if (Clear) begin
         state <= IDLE;
         cnt   <= '0;
         stb   <= '0;
      end else begin
         state <= state_nxt;
         cnt   <= cnt_nxt;
         stb   <= decode_state(state_nxt);
      end
   end

   assign Gra     = stb.gra;
   assign Rout    = stb.rout;
   assign CONin   = stb.con_in;
   assign PCout   = stb.pc_out;
   assign Yin     = stb.y_in;
   assign Cout    = stb.c_out;
   assign ADD     = stb.add;
   assign Zin     = stb.z_in;
   assign Zlowout = stb.zlow_out;
   assign busy    = stb.busy;
   assign done    = stb.done;

   // con_ff is settled long before T6, so gating two flops cannot glitch.
   assign PCin = stb.zlow_out & con_ff;

endmodule

// File: tb/tb_branch_seq_ctrl.sv
// Bench for branch_seq_ctrl: one instance with STEP_CYCLES=1 (sel 0), one with STEP_CYCLES=3 (sel 1).
module tb_branch_seq_ctrl;

   localparam int DW = 32;
`ifdef BRANCH_SKIP_EN
   localparam bit SKIP = 1'b1;
`else
   localparam bit SKIP = 1'b0;
`endif

   logic Clock = 1'b0;
   logic Clear = 1'b1;
   always #5 Clock = ~Clock;

   logic          start_a = 1'b0, start_b = 1'b0;
   logic [1:0]    cond_a = '0, cond_b = '0;
   logic [DW-1:0] bus_a = '0, bus_b = '0;
   // {Gra,Rout,CONin,PCout,Yin,Cout,ADD,Zin,Zlowout,PCin,con_ff,busy,done}
   logic [12:0]   obs_a, obs_b;

   int checks = 0;
   int passes = 0;
   int fails  = 0;
   bit con_m [2];

   branch_seq_ctrl #(.DATA_W(DW), .STEP_CYCLES(1)) dut_a (
      .Clock(Clock), .Clear(Clear), .start(start_a), .cond(cond_a), .bus_in(bus_a),
      .Gra(obs_a[12]), .Rout(obs_a[11]), .CONin(obs_a[10]), .PCout(obs_a[9]), .Yin(obs_a[8]),
      .Cout(obs_a[7]), .ADD(obs_a[6]), .Zin(obs_a[5]), .Zlowout(obs_a[4]), .PCin(obs_a[3]),
      .con_ff(obs_a[2]), .busy(obs_a[1]), .done(obs_a[0]));

   branch_seq_ctrl #(.DATA_W(DW), .STEP_CYCLES(3)) dut_b (
      .Clock(Clock), .Clear(Clear), .start(start_b), .cond(cond_b), .bus_in(bus_b),
      .Gra(obs_b[12]), .Rout(obs_b[11]), .CONin(obs_b[10]), .PCout(obs_b[9]), .Yin(obs_b[8]),
      .Cout(obs_b[7]), .ADD(obs_b[6]), .Zin(obs_b[5]), .Zlowout(obs_b[4]), .PCin(obs_b[3]),
      .con_ff(obs_b[2]), .busy(obs_b[1]), .done(obs_b[0]));

   function automatic bit cond_eval(input logic [1:0] c, input logic [DW-1:0] b);
      case (c)
         2'b00:   return (b == 0);
         2'b01:   return (b != 0);
         2'b10:   return (b[DW-1] == 1'b0);
         default: return (b[DW-1] == 1'b1);
      endcase
   endfunction

   function automatic logic [12:0] idle_vec(input bit c);
      logic [12:0] v;
      v = '0;
      v[2] = c;
      return v;
   endfunction

   // Expected outputs i cycles after the accepting edge: step number is simply i / s.
   function automatic logic [12:0] exp_vec(input int s, input int i, input int len,
                                           input bit c_old, input bit c_new);
      logic [12:0] v;
      v = '0;
      v[1] = 1'b1;
      if (i < s) begin
         v[12:10] = 3'b111;
         v[2]     = c_old;
      end else begin
         v[2] = c_new;
         if (i == len - 1)  v[0] = 1'b1;
         else if (i / s == 1) v[9:8] = 2'b11;
         else if (i / s == 2) v[7:5] = 3'b111;
         else begin
            v[4] = 1'b1;
            v[3] = c_new;
         end
      end
      return v;
   endfunction

   function automatic logic [12:0] obs(input int sel);
      return (sel != 0) ? obs_b : obs_a;
   endfunction

   task automatic check(input string tag, input logic [12:0] o, input logic [12:0] e);
      checks++;
      assert (o === e) passes++;
      else begin
         fails++;
         $error("FAIL %s observed=%b expected=%b", tag, o, e);
      end
   endtask

   task automatic drive(input int sel, input logic st, input logic [1:0] c, input logic [DW-1:0] b);
      if (sel != 0) begin
         start_b = st; cond_b = c; bus_b = b;
      end else begin
         start_a = st; cond_a = c; bus_a = b;
      end
   endtask

   // Called at a negedge with the selected DUT idle; returns at the first idle negedge after FIN.
   task automatic run_seq(input int sel, input logic [1:0] c, input logic [DW-1:0] b,
                          input bit hold, input bit poke, input string tag);
      int s, len;
      bit c_old, c_new;
      logic st;
      s     = (sel != 0) ? 3 : 1;
      c_old = con_m[sel];
      c_new = cond_eval(c, b);
      len   = (SKIP && !c_new) ? s + 1 : 4 * s + 1;
      check({tag, "/idle"}, obs(sel), idle_vec(c_old));
      drive(sel, 1'b1, c, b);
      for (int i = 0; i < len; i++) begin
         @(negedge Clock);
         check($sformatf("%s/cyc%0d", tag, i), obs(sel), exp_vec(s, i, len, c_old, c_new));
         st = hold || (poke && i == s && i < len - 1);
         if (i < s) drive(sel, st, c, b);
         else       drive(sel, st, 2'($urandom_range(3)), $urandom);
      end
      @(negedge Clock);
      con_m[sel] = c_new;
   endtask

   initial begin
      bit c_new;
      logic [DW-1:0] rb;
      con_m[0] = 1'b0;
      con_m[1] = 1'b0;

      #2;
      check("reset_a", obs_a, 13'd0);
      check("reset_b", obs_b, 13'd0);
      @(negedge Clock);
      @(negedge Clock);
      Clear = 1'b0;
      @(negedge Clock);

      run_seq(0, 2'b01, 32'd10, 0, 0, "brnz_10");
      run_seq(0, 2'b00, 32'd0, 0, 0, "brzr_0");
      run_seq(0, 2'b00, 32'd35, 0, 0, "brzr_35");
      run_seq(0, 2'b10, 32'h8000_0000, 0, 0, "brpl_msb");
      run_seq(0, 2'b11, 32'h8000_0000, 0, 0, "brmi_msb");
      run_seq(0, 2'b11, 32'h7FFF_FFFF, 0, 0, "brmi_max");
      run_seq(1, 2'b01, 32'd7, 0, 1, "s3_poke_t4");
      run_seq(1, 2'b00, 32'd35, 0, 1, "s3_not_taken");
      run_seq(0, 2'b10, 32'd1, 1, 0, "hold_first");
      run_seq(0, 2'b11, 32'd1, 0, 0, "hold_second");

      // Async Clear while the STEP_CYCLES=3 instance sits in its first T5 cycle.
      c_new = cond_eval(2'b01, 32'd5);
      drive(1, 1'b1, 2'b01, 32'd5);
      for (int i = 0; i <= 6; i++) begin
         @(negedge Clock);
         check($sformatf("clr_pre/cyc%0d", i), obs_b, exp_vec(3, i, 13, con_m[1], c_new));
         drive(1, 1'b0, 2'b01, 32'd5);
      end
      #1 Clear = 1'b1;
      #1;
      check("clr_async_b", obs_b, 13'd0);
      check("clr_async_a", obs_a, 13'd0);
      con_m[0] = 1'b0;
      con_m[1] = 1'b0;
      @(negedge Clock);
      Clear = 1'b0;
      @(negedge Clock);
      check("clr_after_b", obs_b, idle_vec(1'b0));
      check("clr_after_a", obs_a, idle_vec(1'b0));

      for (int n = 0; n < 16; n++) begin
         case ($urandom_range(3))
            0:       rb = '0;
            1:       rb = 32'h8000_0000 | $urandom;
            2:       rb = 32'h7FFF_FFFF & $urandom;
            default: rb = $urandom;
         endcase
         run_seq(int'($urandom_range(1)), 2'($urandom_range(3)), rb,
                 0, bit'($urandom_range(1)), $sformatf("rand%0d", n));
      end

      check("final_a", obs_a, idle_vec(con_m[0]));
      check("final_b", obs_b, idle_vec(con_m[1]));

      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end

endmodule
